// File: rtl/sw_input_port.sv
`timescale 1ns/1ps
// Switch input port: 2-FF synchronizer, tick-sampled debounce, pending flag and req/valid read.
// Optional macro SW_INPUT_BLOCKING_EN makes reads stall until a fresh (pending) value exists.
module sw_input_port #(
    parameter int WIDTH          = 4,
    parameter int DIVISOR        = 5,
    parameter int STABLE_SAMPLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             pending,
    output logic [WIDTH-1:0] db_value
);

    localparam int CNT_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int STAB_W = $clog2(STABLE_SAMPLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_SAMPLES);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
`ifdef SW_INPUT_BLOCKING_EN
    localparam logic [1:0] WAIT = 2'd3;
`endif

    logic [WIDTH-1:0]  s1_reg, s2_reg;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [WIDTH-1:0]  cand_reg, cand_next;
    logic [STAB_W-1:0] stab_reg, stab_next;
    logic [WIDTH-1:0]  db_value_reg;
    logic [WIDTH-1:0]  rd_data_reg;
    logic              pending_reg;
    logic              rd_valid_reg;
    logic [1:0]        state_reg, state_next;
    logic              tick;
    logic              accept;
    logic              capture;

    assign tick     = (cnt_reg == CNT_LAST);
    assign cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);

    always_comb begin
        cand_next = cand_reg;
        stab_next = stab_reg;
        if (tick) begin
            if (s2_reg == cand_reg) begin
                stab_next = (stab_reg == STAB_MAX) ? STAB_MAX : stab_reg + STAB_ONE;
            end else begin
                cand_next = s2_reg;
                stab_next = STAB_ONE;
            end
        end
    end

    // A candidate becomes the debounced value on the tick its run length reaches the threshold.
    assign accept = tick && (stab_next == STAB_MAX) && (cand_next != db_value_reg);

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rd_req) begin
`ifdef SW_INPUT_BLOCKING_EN
                    if (pending_reg) begin
                        capture    = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
`else
                    capture    = 1'b1;
                    state_next = RESP;
`endif
                end
            end
            RESP: state_next = DONE;
            DONE: begin
                if (!rd_req) begin
                    state_next = IDLE;
                end
            end
`ifdef SW_INPUT_BLOCKING_EN
            WAIT: begin
                if (!rd_req) begin
                    state_next = IDLE;
                end else if (pending_reg) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            cnt_reg  <= '0;
            cand_reg <= '0;
            stab_reg <= '0;
        end else begin
            s1_reg   <= sw;
            s2_reg   <= s1_reg;
            cnt_reg  <= cnt_next;
            cand_reg <= cand_next;
            stab_reg <= stab_next;
        end
    end

    // Pending clears on the capture edge, so an update landing on that same edge stays flagged as unread.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_value_reg <= '0;
            pending_reg  <= 1'b0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            state_reg    <= IDLE;
        end else begin
            if (accept) begin
                db_value_reg <= cand_next;
            end
            if (accept) begin
                pending_reg <= 1'b1;
            end else if (capture) begin
                pending_reg <= 1'b0;
            end
            if (capture) begin
                rd_data_reg <= db_value_reg;
            end
            rd_valid_reg <= capture;
            state_reg    <= state_next;
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign pending  = pending_reg;
    assign db_value = db_value_reg;

endmodule

// File: tb/tb_sw_input_port.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for sw_input_port; reference model works from switch
// history and tick samples rather than the debounce counters.
module tb_sw_input_port;

    localparam int W = 4;
    localparam int D = 5;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw = 4'h8;
    logic         rd_req = 1'b0;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         pending;
    logic [W-1:0] db_value;

    sw_input_port #(.WIDTH(W), .DIVISOR(D), .STABLE_SAMPLES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .pending  (pending),
        .db_value (db_value)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int           edge_n = 0;
    logic [W-1:0] sw_hist[$];
    logic [W-1:0] tick_hist[$];
    logic [W-1:0] m_db = '0;
    logic [W-1:0] m_rd = '0;
    logic         m_pend = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_armed = 1'b1;
    logic [W-1:0] exp_q[$];

    int           pulses_seen = 0;
    logic [W-1:0] last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // The debounced path sees the switch value from two edges earlier.
    function automatic logic [W-1:0] next_sample();
        if (sw_hist.size() >= 2) return sw_hist[sw_hist.size()-2];
        return '0;
    endfunction

    // True when the coming edge is a tick that completes S equal samples of a new value.
    function automatic bit would_update();
        logic [W-1:0] smp;
        if (((edge_n + 1) % D) != 0) return 1'b0;
        smp = next_sample();
        if (smp == m_db) return 1'b0;
        if (tick_hist.size() < S - 1) return 1'b0;
        for (int k = 1; k < S; k++) begin
            if (tick_hist[tick_hist.size()-k] != smp) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_edge
        logic         upd;
        logic         cap;
        logic         rearm;
        logic [W-1:0] smp;
        logic [W-1:0] old_db;
        if (!rst_n) begin
            edge_n = 0;
            sw_hist.delete();
            tick_hist.delete();
            exp_q.delete();
            m_db    = '0;
            m_rd    = '0;
            m_pend  = 1'b0;
            m_valid = 1'b0;
            m_armed = 1'b1;
        end else begin
            upd    = would_update();
            smp    = next_sample();
            old_db = m_db;
`ifdef SW_INPUT_BLOCKING_EN
            cap = rd_req && m_armed && m_pend;
`else
            cap = rd_req && m_armed;
`endif
            rearm = !rd_req && !m_valid && !m_armed;
            edge_n++;
            sw_hist.push_back(sw);
            if ((edge_n % D) == 0) tick_hist.push_back(smp);
            if (upd) m_db = smp;
            if (upd) m_pend = 1'b1;
            else if (cap) m_pend = 1'b0;
            if (cap) begin
                m_rd = old_db;
                exp_q.push_back(old_db);
                m_armed = 1'b0;
            end else if (rearm) begin
                m_armed = 1'b1;
            end
            m_valid = cap;
        end
    end

    // Monitor: cycle checks against the model plus scoreboard pop on each read pulse.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n) begin
            check("db_value", 32'(db_value), 32'(m_db));
            check("pending", 32'(pending), 32'(m_pend));
            check("rd_valid", 32'(rd_valid), 32'(m_valid));
            check("rd_data_hold", 32'(rd_data), 32'(m_rd));
            if (rd_valid) begin
                pulses_seen++;
                last_rd = rd_data;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual=rd_valid required=none data=%0h time=%0t", rd_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rd_data", 32'(rd_data), 32'(e));
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read(input int hold);
        @(negedge clk);
        rd_req = 1'b1;
        repeat (hold) @(negedge clk);
        rd_req = 1'b0;
        wait_cycles(3);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_pending"}, 32'(pending), 32'd0);
        check({tag, "_db_value"}, 32'(db_value), 32'd0);
    endtask

    initial begin
        int           p0;
        bit           hit;
        int           r;
        logic [W-1:0] gb;

        // Reset with sw = 8 held, then release and expect acceptance within 18 cycles.
        #12;
        check_all_zero("reset");
        wait_cycles(2);
        rst_n = 1'b1;
        p0 = pulses_seen;
        wait_cycles(18);
        check("settle8_db", 32'(db_value), 32'h8);
        check("settle8_pending", 32'(pending), 32'd1);
        check("settle8_no_pulse", 32'(pulses_seen - p0), 32'd0);

        // Read, then a 7-cycle glitch to 9 must be rejected.
        do_read(1);
        check("read8_data", 32'(last_rd), 32'h8);
        @(negedge clk);
        sw = 4'h9;
        wait_cycles(7);
        sw = 4'h8;
        wait_cycles(30);
        check("glitch_db", 32'(db_value), 32'h8);
        check("glitch_pending", 32'(pending), 32'd0);

        // Single-cycle request on a stable 3.
        sw = 4'h3;
        wait_cycles(30);
        p0 = pulses_seen;
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        check("pulse_timing", 32'(rd_valid), 32'd1);
        check("pulse_data", 32'(rd_data), 32'h3);
        @(negedge clk);
        check("pulse_pending_clear", 32'(pending), 32'd0);
        wait_cycles(5);
        check("pulse_count_single", 32'(pulses_seen - p0), 32'd1);

        // Held request gives one pulse only.
        p0 = pulses_seen;
        do_read(20);
        check("held_pulse_count", 32'(pulses_seen - p0), 32'd1);
`ifndef SW_INPUT_BLOCKING_EN
        do_read(1);
        check("reread_data", 32'(last_rd), 32'h3);
        check("reread_pending", 32'(pending), 32'd0);
        check("reread_count", 32'(pulses_seen - p0), 32'd2);

        // Update coinciding with the capture edge: old value returned, pending survives.
        sw = 4'h8;
        wait_cycles(30);
        do_read(1);
        sw = 4'h9;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (would_update() && m_armed) begin
                rd_req = 1'b1;
                hit = 1'b1;
            end
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL coincide_timeout actual=no_update required=update_within_60");
        end else begin
            @(negedge clk);
            rd_req = 1'b0;
            check("coincide_valid", 32'(rd_valid), 32'd1);
            check("coincide_data", 32'(rd_data), 32'h8);
            check("coincide_pending", 32'(pending), 32'd1);
            wait_cycles(3);
            do_read(1);
            check("coincide_next_data", 32'(last_rd), 32'h9);
        end
`endif

        // Asynchronous reset while in RESP.
        sw = 4'h6;
        wait_cycles(30);
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("arst_resp");
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(30);

        // Asynchronous reset while in DONE with the request still held.
        @(negedge clk);
        rd_req = 1'b1;
        wait_cycles(4);
        #2 rst_n = 1'b0;
        #1 check_all_zero("arst_done");
        rd_req = 1'b0;
        sw = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(25);
        check("zero_no_pending", 32'(pending), 32'd0);

`ifdef SW_INPUT_BLOCKING_EN
        // Blocking read stalls until a fresh value arrives.
        p0 = pulses_seen;
        @(negedge clk);
        rd_req = 1'b1;
        wait_cycles(15);
        check("block_stall", 32'(pulses_seen - p0), 32'd0);
        sw = 4'h5;
        for (int i = 0; i < 40 && !rd_valid; i++) @(negedge clk);
        if (!rd_valid) begin
            checks++;
            failures++;
            $display("FAIL block_timeout actual=no_pulse required=pulse_within_40");
        end else begin
            check("block_data", 32'(rd_data), 32'h5);
        end
        rd_req = 1'b0;
        wait_cycles(3);
`else
        // Non-blocking read with nothing pending returns the current value at once.
        sw = 4'h5;
        wait_cycles(30);
        do_read(1);
        do_read(1);
        check("nonblock_data", 32'(last_rd), 32'h5);
        check("nonblock_pending", 32'(pending), 32'd0);
`endif

        // Randomized traffic: value changes, glitches, reads and occasional resets.
        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 19);
            if (r < 7) begin
                sw = 4'($urandom_range(0, 15));
            end else if (r < 10) begin
                gb = 4'(1 << $urandom_range(0, 3));
                sw = sw ^ gb;
                wait_cycles($urandom_range(1, 8));
                sw = sw ^ gb;
            end else if (r < 19) begin
                do_read($urandom_range(1, 6));
            end else begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            wait_cycles($urandom_range(1, 25));
        end

        rd_req = 1'b0;
        wait_cycles(40);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
